// File: rtl/sm4_engine.sv
// SM4 block-cipher engine: one-shot key expansion into a 32-entry round-key cache,
// then encrypt/decrypt of 128-bit blocks at ROUNDS_PER_CYCLE rounds per clock.
module sm4_engine #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int OUT_REG          = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         KEY_VALID,
  output logic         KEY_READY,
  input  logic [127:0] IN_KEY,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic         IN_DECRYPT,
  input  logic [127:0] IN_DATA,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         KEY_LOADED
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [4:0]   LAST_CNT = 5'(32 - R);
  localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;

  localparam logic [0:255][7:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  if (OUT_REG != 1 || (R != 1 && R != 2 && R != 4 && R != 8)) begin : g_bad_param
    $error("sm4_engine: unsupported ROUNDS_PER_CYCLE or OUT_REG");
  end

  typedef enum logic [1:0] {IDLE, KEYEXP, CRYPT, DONE} state_t;

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  function automatic logic [31:0] l_data(input logic [31:0] b);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  // CK(i) byte j is (4i+j)*7 mod 256, byte 0 in the top lane.
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'((4 * int'(i) + j) * 7);
    return w;
  endfunction

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [127:0]        w_q, w_d;
  logic                dec_q, dec_d;
  logic                key_loaded_q, key_loaded_d;
  logic                out_valid_q, out_valid_d;
  logic [127:0]        out_data_q, out_data_d;
  logic [31:0][31:0]   rk_q, rk_d;
  logic [R-1:0][31:0]  mix_w;
  logic [127:0]        st;
  logic [31:0]         x, nw;

  // Per-round constant: CK during key expansion, cached round key during crypt.
  for (genvar gi = 0; gi < R; gi++) begin : g_round
    logic [4:0] idx;
    assign idx = cnt_q + 5'(gi);
    assign mix_w[gi] = (state_q == KEYEXP) ? ck_word(idx)
                                           : rk_q[dec_q ? (5'd31 - idx) : idx];
  end

  // Unrolled round chain shared by key expansion and data rounds.
  always_comb begin
    st   = w_q;
    rk_d = rk_q;
    x    = '0;
    nw   = '0;
    for (int r = 0; r < R; r++) begin
      x  = st[95:64] ^ st[63:32] ^ st[31:0] ^ mix_w[r];
      nw = st[127:96] ^ ((state_q == KEYEXP) ? l_key(tau(x)) : l_data(tau(x)));
      if (state_q == KEYEXP) rk_d[cnt_q + 5'(r)] = nw;
      st = {st[95:0], nw};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    w_d          = w_q;
    dec_d        = dec_q;
    key_loaded_d = key_loaded_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    case (state_q)
      IDLE: begin
        // A pending key waits while a block is accepted in the same cycle.
        if (IN_VALID && key_loaded_q) begin
          w_d     = IN_DATA;
          dec_d   = IN_DECRYPT;
          cnt_d   = '0;
          state_d = CRYPT;
        end else if (KEY_VALID) begin
          w_d          = IN_KEY ^ FK;
          cnt_d        = '0;
          key_loaded_d = 1'b0;
          state_d      = KEYEXP;
        end
      end
      KEYEXP: begin
        w_d   = st;
        cnt_d = cnt_q + 5'(R);
        if (cnt_q == LAST_CNT) begin
          key_loaded_d = 1'b1;
          state_d      = IDLE;
        end
      end
      CRYPT: begin
        w_d   = st;
        cnt_d = cnt_q + 5'(R);
        if (cnt_q == LAST_CNT) begin
          out_data_d  = {st[31:0], st[63:32], st[95:64], st[127:96]};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      w_q          <= '0;
      dec_q        <= 1'b0;
      key_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      w_q          <= w_d;
      dec_q        <= dec_d;
      key_loaded_q <= key_loaded_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // Cache contents are meaningless until KEY_LOADED, so no reset here.
  always_ff @(posedge CLK) begin
    rk_q <= rk_d;
  end

  assign KEY_READY  = (state_q == IDLE);
  assign IN_READY   = (state_q == IDLE) && key_loaded_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_DATA   = out_data_q;
  assign KEY_LOADED = key_loaded_q;

endmodule

// File: tb/tb_sm4_engine.sv
// Directed bench for sm4_engine: standard SM4 vector, round trips, back-pressure,
// reset aborts and the simultaneous key/data case.
module tb_sm4_engine;
  localparam int R   = 1;
  localparam int LAT = 32 / R;

  localparam logic [127:0] K1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P1 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C1 = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst, key_valid, key_ready, in_valid, in_ready, in_decrypt;
  logic         out_valid, out_ready, key_loaded;
  logic [127:0] in_key, in_data, out_data;

  always #5 clk = ~clk;

  sm4_engine #(.ROUNDS_PER_CYCLE(R), .OUT_REG(1)) dut (
    .CLK(clk), .RST(rst),
    .KEY_VALID(key_valid), .KEY_READY(key_ready), .IN_KEY(in_key),
    .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DECRYPT(in_decrypt), .IN_DATA(in_data),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .KEY_LOADED(key_loaded)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [127:0] data;
    logic         dec;
    logic [127:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [127:0] act, input logic [127:0] bad);
    checks++;
    if (act === bad) begin
      errors++;
      $display("FAIL %s: got %h must differ from %h", name, act, bad);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 200);
    check("out_valid rises", 128'(out_valid), 128'(1));
  endtask

  task automatic wait_key(output int n);
    n = 0;
    do begin tick(); n++; end while (!key_loaded && n < 200);
    check("key_loaded rises", 128'(key_loaded), 128'(1));
  endtask

  task automatic do_key(input logic [127:0] k);
    int n;
    check("key_ready idle", 128'(key_ready), 128'(1));
    key_valid = 1'b1;
    in_key    = k;
    tick();
    key_valid = 1'b0;
    check("keyexp key_loaded", 128'(key_loaded), 128'(0));
    check("keyexp key_ready", 128'(key_ready), 128'(0));
    wait_key(n);
    check("key latency", 128'(n), 128'(LAT));
    $display("key %h loaded after %0d cycles", k, n);
  endtask

  task automatic do_block(input logic [127:0] d, input logic dec,
                          output logic [127:0] res, output int n);
    check("in_ready before accept", 128'(in_ready), 128'(1));
    in_valid   = 1'b1;
    in_data    = d;
    in_decrypt = dec;
    tick();
    in_valid = 1'b0;
    check("in_ready in crypt", 128'(in_ready), 128'(0));
    wait_out(n);
    res = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid drops", 128'(out_valid), 128'(0));
    $display("block %s %h -> %h in %0d cycles", dec ? "dec" : "enc", d, res, n);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " key_loaded"}, 128'(key_loaded), 128'(0));
    check({tag, " out_valid"}, 128'(out_valid), 128'(0));
    check({tag, " out_data"}, out_data, 128'(0));
    check({tag, " key_ready"}, 128'(key_ready), 128'(1));
    check({tag, " in_ready"}, 128'(in_ready), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[4];
    logic [127:0] res, res2, p;
    int           n;
    bit           seen;

    vecs[0] = '{"std enc",    P1, 1'b0, C1};
    vecs[1] = '{"std dec",    C1, 1'b1, P1};
    vecs[2] = '{"std enc 2",  P1, 1'b0, C1};
    vecs[3] = '{"std dec 2",  C1, 1'b1, P1};

    rst = 1'b1; key_valid = 1'b0; in_valid = 1'b0; in_decrypt = 1'b0;
    out_ready = 1'b0; in_key = '0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    reset_checks("reset");

    do_key(K1);
    check("in_ready after key", 128'(in_ready), 128'(1));

    for (int i = 0; i < 4; i++) begin
      do_block(vecs[i].data, vecs[i].dec, res, n);
      check(vecs[i].name, res, vecs[i].exp);
      check({vecs[i].name, " latency"}, 128'(n), 128'(LAT));
      check({vecs[i].name, " key_loaded"}, 128'(key_loaded), 128'(1));
    end

    // Back-pressure: result held, second block offered but not taken until release.
    in_valid = 1'b1; in_data = P1; in_decrypt = 1'b0;
    tick();
    in_data = C1; in_decrypt = 1'b1;
    wait_out(n);
    check("bp latency", 128'(n), 128'(LAT));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp out_data held", out_data, C1);
      check("bp out_valid held", 128'(out_valid), 128'(1));
      check("bp in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp released", 128'(out_valid), 128'(0));
    check("bp in_ready idle", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    wait_out(n);
    check("bp second block", out_data, P1);
    $display("backpressure second block -> %h", out_data);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Round trips with random plaintexts.
    for (int i = 0; i < 3; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      do_block(p, 1'b0, res, n);
      check_ne("rt ciphertext", res, p);
      do_block(res, 1'b1, res2, n);
      check("rt plaintext", res2, p);
    end

    // Simultaneous key and data: data uses the old key, key taken afterwards.
    key_valid = 1'b1; in_key = K2;
    in_valid = 1'b1; in_data = P1; in_decrypt = 1'b0;
    tick();
    in_valid = 1'b0;
    check("sim key_loaded kept", 128'(key_loaded), 128'(1));
    check("sim key_ready busy", 128'(key_ready), 128'(0));
    wait_out(n);
    check("sim old-key block", out_data, C1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("sim key_ready idle", 128'(key_ready), 128'(1));
    tick();
    key_valid = 1'b0;
    check("sim keyexp started", 128'(key_loaded), 128'(0));
    check("sim in_ready keyexp", 128'(in_ready), 128'(0));
    wait_key(n);
    check("sim key latency", 128'(n), 128'(LAT));
    do_block(P1, 1'b0, res, n);
    check_ne("new key ciphertext", res, C1);
    do_block(res, 1'b1, res2, n);
    check("new key round trip", res2, P1);

    // Reset in the middle of key expansion.
    key_valid = 1'b1; in_key = K1;
    tick();
    key_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_checks("rst keyexp");

    // Reset in the middle of a block; no result may appear afterwards.
    do_key(K1);
    in_valid = 1'b1; in_data = P1; in_decrypt = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reset_checks("rst crypt");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("no result after abort", 128'(seen), 128'(0));

    do_key(K1);
    do_block(P1, 1'b0, res, n);
    check("recovery enc", res, C1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
